// File: rtl/mv_pkg.sv
// mv_collector shared types: packed result entry and raster position.
// Field order of mv_entry_t is the mv_data bit layout, MSB first.
package mv_pkg;

  localparam int SAD_W     = 14;
  localparam int MV_W      = 4;
  localparam int BLK_W     = 8;
  localparam int MV_DATA_W = 2 * BLK_W + 2 * MV_W + SAD_W;

  localparam int DEF_BLK_COLS = 240;
  localparam int DEF_BLK_ROWS = 135;

  typedef struct packed {
    logic [BLK_W-1:0] blk_y;
    logic [BLK_W-1:0] blk_x;
    logic [MV_W-1:0]  mv_y;
    logic [MV_W-1:0]  mv_x;
    logic [SAD_W-1:0] sad;
  } mv_entry_t;

  typedef struct packed {
    logic [BLK_W-1:0] y;
    logic [BLK_W-1:0] x;
  } blk_pos_t;

  function automatic blk_pos_t pos_next(
    input blk_pos_t p,
    input int       cols,
    input int       rows
  );
    blk_pos_t n;
    n = p;
    if (p.x == BLK_W'(cols - 1)) begin
      n.x = '0;
      if (p.y == BLK_W'(rows - 1)) begin
        n.y = '0;
      end else begin
        n.y = p.y + 1'b1;
      end
    end else begin
      n.x = p.x + 1'b1;
    end
    return n;
  endfunction

endpackage

// File: rtl/mv_collector_if.sv
// Result stream towards write-back: show-ahead valid/ready bus.
// master drives valid/data, slave drives ready.
interface mv_collector_if;
  import mv_pkg::*;

  logic                 mv_valid;
  logic                 mv_ready;
  logic [MV_DATA_W-1:0] mv_data;

  modport master (
    output mv_valid,
    output mv_data,
    input  mv_ready
  );

  modport slave (
    input  mv_valid,
    input  mv_data,
    output mv_ready
  );

endinterface

// File: rtl/mv_fifo.sv
// Synchronous show-ahead FIFO; head entry is visible while not empty.
// A push into a full FIFO succeeds only when a pop happens that cycle.
module mv_fifo #(
  parameter int WIDTH = 38,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic [WIDTH-1:0]       din_i,
  output logic [WIDTH-1:0]       dout_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, wr_d;
  logic [AW-1:0]    rd_q, rd_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign dout_o  = empty_o ? '0 : mem_q[rd_q];

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
    if (do_push) wr_d = wr_q + 1'b1;
    if (do_pop)  rd_d = rd_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
      if (do_push) mem_q[wr_q] <= din_i;
    end
  end

endmodule

// File: rtl/mv_collector.sv
// Tags SAD/compare results with raster block position and buffers
// them for write-back; flags dropped results and end of frame.
module mv_collector
  import mv_pkg::*;
#(
  parameter int CAP_DLY    = 1,
  parameter int BLK_COLS   = DEF_BLK_COLS,
  parameter int BLK_ROWS   = DEF_BLK_ROWS,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        frame_start,
  input  logic                        sad_en,
  input  logic [SAD_W-1:0]            sad_min,
  input  logic [MV_W-1:0]             motion_vec_x_min,
  input  logic [MV_W-1:0]             motion_vec_y_min,
  mv_collector_if.master              mv,
  output logic [$clog2(FIFO_DEPTH):0] fifo_cnt,
  output logic                        overflow,
  output logic                        frame_done
);

  if (CAP_DLY < 0 || CAP_DLY > 8 ||
      BLK_COLS < 1 || BLK_COLS > 256 ||
      BLK_ROWS < 1 || BLK_ROWS > 256 ||
      FIFO_DEPTH < 2 ||
      (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)
  begin : g_bad_param
    $error("mv_collector: parameter out of range");
  end

  logic cap;

  if (CAP_DLY == 0) begin : g_nodly
    assign cap = sad_en;
  end else begin : g_dly
    logic [CAP_DLY-1:0] dly_q, dly_d;

    assign dly_d = (dly_q << 1) | CAP_DLY'(sad_en);
    assign cap   = dly_q[CAP_DLY-1];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) dly_q <= '0;
      else        dly_q <= dly_d;
    end
  end

  localparam logic [BLK_W-1:0] LAST_X = BLK_W'(BLK_COLS - 1);
  localparam logic [BLK_W-1:0] LAST_Y = BLK_W'(BLK_ROWS - 1);

  blk_pos_t  pos_q, pos_d;
  blk_pos_t  tag;
  mv_entry_t ent;
  logic      done_q, done_d;
  logic      ovf_q, ovf_d;
  logic      full;
  logic      empty;
  logic      pop;

  // frame_start wins over the running position for a coincident cap
  assign tag = frame_start ? '0 : pos_q;

  always_comb begin
    pos_d  = pos_q;
    done_d = 1'b0;
    unique case (1'b1)
      cap: begin
        pos_d  = pos_next(tag, BLK_COLS, BLK_ROWS);
        done_d = (tag.x == LAST_X) && (tag.y == LAST_Y);
      end
      (!cap && frame_start): begin
        pos_d = '0;
      end
      default: ;
    endcase
  end

  always_comb begin
    ent       = '0;
    ent.blk_y = tag.y;
    ent.blk_x = tag.x;
    ent.mv_y  = motion_vec_y_min;
    ent.mv_x  = motion_vec_x_min;
    ent.sad   = sad_min;
  end

  assign pop   = mv.mv_valid && mv.mv_ready;
  assign ovf_d = ovf_q || (cap && full && !pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos_q  <= '0;
      done_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      pos_q  <= pos_d;
      done_q <= done_d;
      ovf_q  <= ovf_d;
    end
  end

  mv_fifo #(
    .WIDTH (MV_DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (cap),
    .pop_i   (pop),
    .din_i   (ent),
    .dout_o  (mv.mv_data),
    .full_o  (full),
    .empty_o (empty),
    .count_o (fifo_cnt)
  );

  assign mv.mv_valid = !empty;
  assign overflow    = ovf_q;
  assign frame_done  = done_q;

endmodule

// File: tb/tb_mv_collector.sv
// Scoreboard bench for mv_collector: two instances, a at 240x135
// with CAP_DLY=1, b at 3x2 with CAP_DLY=2.
module tb_mv_collector;
  import mv_pkg::*;

  localparam int DLY_A = 1;
  localparam int DLY_B = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fs_a, fs_b;
  logic        en_a, en_b;
  logic [13:0] sad;
  logic [3:0]  mx, my;
  logic [2:0]  cnt_a, cnt_b;
  logic        ovf_a, ovf_b;
  logic        fd_a, fd_b;

  always #5 clk = ~clk;

  mv_collector_if ifa ();
  mv_collector_if ifb ();

  mv_collector #(
    .CAP_DLY    (DLY_A),
    .FIFO_DEPTH (4)
  ) u_a (
    .clk              (clk),
    .rst_n            (rst_n),
    .frame_start      (fs_a),
    .sad_en           (en_a),
    .sad_min          (sad),
    .motion_vec_x_min (mx),
    .motion_vec_y_min (my),
    .mv               (ifa),
    .fifo_cnt         (cnt_a),
    .overflow         (ovf_a),
    .frame_done       (fd_a)
  );

  mv_collector #(
    .CAP_DLY    (DLY_B),
    .BLK_COLS   (3),
    .BLK_ROWS   (2),
    .FIFO_DEPTH (4)
  ) u_b (
    .clk              (clk),
    .rst_n            (rst_n),
    .frame_start      (fs_b),
    .sad_en           (en_b),
    .sad_min          (sad),
    .motion_vec_x_min (mx),
    .motion_vec_y_min (my),
    .mv               (ifb),
    .fifo_cnt         (cnt_b),
    .overflow         (ovf_b),
    .frame_done       (fd_b)
  );

  int          checks = 0;
  int          errors = 0;
  int          fd_cnt = 0;
  logic [37:0] qa[$];
  logic [37:0] qb[$];
  logic [37:0] exp_a, exp_b;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && ifa.mv_valid && ifa.mv_ready) begin
      checks++;
      if (qa.size() == 0) begin
        errors++;
        $display("FAIL mon_a act=%0h exp=none", ifa.mv_data);
      end else begin
        exp_a = qa.pop_front();
        if (ifa.mv_data !== exp_a) begin
          errors++;
          $display("FAIL mon_a act=%0h exp=%0h",
                   ifa.mv_data, exp_a);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && fd_b) fd_cnt++;
    if (rst_n && ifb.mv_valid && ifb.mv_ready) begin
      checks++;
      if (qb.size() == 0) begin
        errors++;
        $display("FAIL mon_b act=%0h exp=none", ifb.mv_data);
      end else begin
        exp_b = qb.pop_front();
        if (ifb.mv_data !== exp_b) begin
          errors++;
          $display("FAIL mon_b act=%0h exp=%0h",
                   ifb.mv_data, exp_b);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // strobe, then hold data (and optional frame_start) until capture
  task automatic send(input bit d,
                      input logic [13:0] s,
                      input logic [3:0] x,
                      input logic [3:0] y,
                      input logic [7:0] bx,
                      input logic [7:0] by,
                      input bit keep,
                      input bit fs);
    int hold;
    hold = d ? DLY_B : DLY_A;
    if (keep) begin
      if (d) qb.push_back({by, bx, y, x, s});
      else   qa.push_back({by, bx, y, x, s});
    end
    sad = s;
    mx  = x;
    my  = y;
    if (d) en_b = 1'b1;
    else   en_a = 1'b1;
    tick();
    en_a = 1'b0;
    en_b = 1'b0;
    for (int i = 0; i < hold; i++) begin
      if (i == hold - 1) begin
        if (d) fs_b = fs;
        else   fs_a = fs;
      end
      tick();
    end
    fs_a = 1'b0;
    fs_b = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    qa.delete();
    qb.delete();
    rst_n = 1'b1;
    tick();
  endtask

  int tx[7] = '{0, 1, 2, 0, 1, 2, 0};
  int ty[7] = '{0, 0, 0, 1, 1, 1, 0};

  initial begin
    rst_n = 1'b0;
    fs_a = 1'b0;
    fs_b = 1'b0;
    en_a = 1'b0;
    en_b = 1'b0;
    sad = '0;
    mx = '0;
    my = '0;
    ifa.mv_ready = 1'b0;
    ifb.mv_ready = 1'b1;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    chk("rst_valid", ifa.mv_valid, 0);
    chk("rst_data", ifa.mv_data, 0);
    chk("rst_cnt", cnt_a, 0);
    chk("rst_ovf", ovf_a, 0);
    chk("rst_fd", fd_a, 0);
    chk("rst_valid_b", ifb.mv_valid, 0);

    // single result, immediate drain
    ifa.mv_ready = 1'b1;
    repeat (5) tick();
    send(0, 14'h123, 4'd5, 4'd9, 8'd0, 8'd0, 1, 0);
    chk("t1_valid_hi", ifa.mv_valid, 1);
    tick();
    chk("t1_valid_lo", ifa.mv_valid, 0);
    chk("t1_q_empty", qa.size(), 0);

    // backpressure and overflow
    do_reset();
    ifa.mv_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      send(0, 14'(16 + i), 4'(i), 4'(15 - i),
           8'(i), 8'd0, i < 4, 0);
    end
    chk("t2_cnt_full", cnt_a, 4);
    chk("t2_ovf_set", ovf_a, 1);
    ifa.mv_ready = 1'b1;
    repeat (4) tick();
    chk("t2_cnt_drained", cnt_a, 0);
    chk("t2_ovf_sticky", ovf_a, 1);
    send(0, 14'h3fff, 4'hf, 4'h0, 8'd5, 8'd0, 1, 0);
    tick();
    chk("t2_q_empty", qa.size(), 0);

    // raster wrap on the 3x2 instance
    do_reset();
    fd_cnt = 0;
    for (int i = 0; i < 7; i++) begin
      send(1, 14'(100 + i), 4'(i), 4'(i + 1),
           8'(tx[i]), 8'(ty[i]), 1, 0);
      chk("t3_fd", fd_b, (i == 5));
    end
    tick();
    chk("t3_fd_cnt", fd_cnt, 1);
    chk("t3_q_empty", qb.size(), 0);

    // frame_start coincident with a capture
    do_reset();
    chk("t4_ovf_clr", ovf_a, 0);
    ifa.mv_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      send(0, 14'(200 + i), 4'd1, 4'd2, 8'(i), 8'd0, 1, 0);
    end
    chk("t4_cnt", cnt_a, 4);
    ifa.mv_ready = 1'b1;
    send(0, 14'h0aa, 4'd3, 4'd3, 8'd0, 8'd0, 1, 1);
    send(0, 14'h0bb, 4'd4, 4'd4, 8'd1, 8'd0, 1, 0);
    repeat (6) tick();
    chk("t4_q_empty", qa.size(), 0);
    chk("t4_ovf", ovf_a, 0);

    // full FIFO with push and pop in the same cycle
    do_reset();
    ifa.mv_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      send(0, 14'(300 + i), 4'd2, 4'd1, 8'(i), 8'd0, 1, 0);
    end
    chk("t5_cnt_full", cnt_a, 4);
    qa.push_back({8'd0, 8'd4, 4'd7, 4'd6, 14'h155});
    sad = 14'h155;
    mx = 4'd6;
    my = 4'd7;
    en_a = 1'b1;
    tick();
    en_a = 1'b0;
    ifa.mv_ready = 1'b1;
    tick();
    ifa.mv_ready = 1'b0;
    chk("t5_cnt_same", cnt_a, 4);
    chk("t5_ovf_clear", ovf_a, 0);
    fs_a = 1'b1;
    tick();
    fs_a = 1'b0;
    chk("t5_fs_cnt", cnt_a, 4);
    chk("t5_fs_ovf", ovf_a, 0);
    ifa.mv_ready = 1'b1;
    repeat (4) tick();
    chk("t5_cnt_drained", cnt_a, 0);
    send(0, 14'h002, 4'd1, 4'd1, 8'd0, 8'd0, 1, 0);
    tick();
    chk("t5_q_empty", qa.size(), 0);

    // asynchronous reset with buffered entries
    ifa.mv_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      send(0, 14'(400 + i), 4'd3, 4'd3, 8'(i + 1), 8'd0, 0, 0);
    end
    chk("t6_cnt_pre", cnt_a, 3);
    #1;
    rst_n = 1'b0;
    #1;
    chk("t6_valid", ifa.mv_valid, 0);
    chk("t6_cnt", cnt_a, 0);
    chk("t6_ovf", ovf_a, 0);
    qa.delete();
    tick();
    rst_n = 1'b1;
    tick();
    ifa.mv_ready = 1'b1;
    send(0, 14'h077, 4'd2, 4'd3, 8'd0, 8'd0, 1, 0);
    chk("t6_valid_new", ifa.mv_valid, 1);
    tick();
    chk("t6_q_empty", qa.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mv_collector.md
Name: mv_collector

Overview:
- Downstream of the SAD/compare core; consumes its per-block result strobe (sad_en, sad_min, motion_vec_x_min, motion_vec_y_min).
- Tags each result with its raster block position (blk_x, blk_y) and buffers it in a small FIFO.
- Presents results to the write-back/AXI side over a valid/ready handshake.
- Tracks frame boundaries, flags overflow and pulses at end of frame.

Parameters:
- CAP_DLY, 1, cycles between sampling sad_en high and capturing the result inputs (0..8).
- BLK_COLS, 240, blocks per row (3840/16).
- BLK_ROWS, 135, block rows per frame (2160/16).
- FIFO_DEPTH, 4, entries; power of two, >=2.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- frame_start  in  1  single-cycle pulse; restarts block position at (0,0).
- sad_en  in  1  result strobe from core, one cycle per block.
- sad_min  in  14  minimum SAD of block.
- motion_vec_x_min  in  4  best horizontal offset.
- motion_vec_y_min  in  4  best vertical offset.
- mv_valid  out  1  FIFO head valid.
- mv_ready  in  1  consumer accepts head when mv_valid&&mv_ready.
- mv_data  out  38  packed head entry.
- fifo_cnt  out  $clog2(FIFO_DEPTH)+1  current occupancy.
- overflow  out  1  sticky: a result was dropped.
- frame_done  out  1  one-cycle pulse after last block of frame captured.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rst_n.
- Reset values: mv_valid=0, mv_data=0, fifo_cnt=0, overflow=0, frame_done=0, blk_x=blk_y=0, delay line=0, FIFO pointers=0.
- Capture strobe:
  - sad_en is delayed CAP_DLY cycles through a shift register; cap = delayed bit (cap = sad_en when CAP_DLY=0).
  - On an edge where cap=1, sample sad_min and both motion vectors.
- Packing:
  - mv_data[37:30]=blk_y, [29:22]=blk_x, [21:18]=mv_y, [17:14]=mv_x, [13:0]=sad.
  - blk_x and blk_y are 8 bits; parameters must fit.
- Position counter:
  - Advances on every cap, including dropped ones, so tags stay spatially correct.
  - blk_x increments; at BLK_COLS-1 it wraps to 0 and blk_y increments.
  - At (BLK_COLS-1, BLK_ROWS-1) both wrap to 0 and frame_done pulses on the next cycle.
- frame_start:
  - Forces the position to (0,0).
  - If it coincides with cap, that entry is tagged (0,0) and the position becomes (1,0).
  - Does not touch FIFO contents or overflow.
- FIFO:
  - Show-ahead. mv_data is the head entry; it is held stable while mv_valid && !mv_ready.
  - Push on cap; pop on mv_valid && mv_ready.
  - Latency: entry captured at edge E gives mv_valid=1 in the cycle after E, when the FIFO was empty.
  - Full + push + pop in the same cycle: both succeed and fifo_cnt is unchanged.
  - Full + push, no pop: entry dropped, overflow set (sticky until reset), fifo_cnt stays FIFO_DEPTH.
  - Empty + pop cannot occur, since mv_valid=0 when empty.
  - Pointers wrap modulo FIFO_DEPTH.
- Reset mid-operation: all state clears immediately (async); buffered entries are lost; the first cap after release is tagged (0,0).

Decomposition:
- Shared package mv_pkg holds:
  - MV_DATA_W=38 and field offsets/widths (SAD_W=14, MV_W=4, BLK_W=8).
  - Default BLK_COLS/BLK_ROWS constants.
- Sub-module mv_fifo: synchronous show-ahead FIFO with WIDTH/DEPTH parameters and push, pop, full, empty, count.
- mv_collector contains the delay line, position counter, packing and flag logic.

Test Plan:
- Single result, CAP_DLY=1, mv_ready=1: sad_en pulse at cycle 10 with sad=0x123, x=5, y=9 -> mv_valid=1 in cycle 12 only; mv_data={8'd0, 8'd0, 4'd9, 4'd5, 14'h123}.
- Backpressure/overflow, FIFO_DEPTH=4, mv_ready=0, 5 results -> fifo_cnt=4, overflow=1. Then mv_ready=1 drains 4 entries with blk_x=0,1,2,3 in order; the next result is tagged blk_x=5.
- Raster wrap, BLK_COLS=3, BLK_ROWS=2, 7 results -> tags (0,0),(1,0),(2,0),(0,1),(1,1),(2,1),(0,0). frame_done is high exactly one cycle, after the 6th capture.
- frame_start mid-frame: after 4 results, frame_start coincides with the 5th cap -> 5th tagged (0,0), 6th tagged (1,0); FIFO contents unaffected.
- Full with simultaneous pop: FIFO full, mv_ready=1 on the same cycle as cap -> fifo_cnt stays 4, overflow stays 0, new entry appears last in order.
- Reset mid-operation: rst_n low for 1 cycle with 3 buffered entries -> mv_valid=0, fifo_cnt=0, overflow=0 immediately; the next result is tagged (0,0).
